// File: rtl/product_display.sv
// product_display: converts an 8-bit unsigned product to 3-digit BCD using a
// sequential double-dabble engine (8 cycles per conversion). It then scans the
// digits onto a 4-digit, active-low, common-anode 7-segment display.
// Latency: a new result sampled at IDLE edge N appears on bcd at edge N+8.
//   busy is high for exactly 8 cycles.
// Backpressure: none. Input changes during a conversion are picked up on the
//   next IDLE cycle, by comparing the input against the last converted value.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading-zero digits.
// Ports:
//   clk            system clock (posedge)
//   rst            synchronous active-high reset
//   result[7:0]    unsigned value to display
//   bcd[11:0]      {hundreds,tens,ones} of last completed conversion
//   busy           conversion in progress
//   an[3:0]        digit anodes, active-low one-hot, an[0] = ones
//   seg[6:0]       segments {g,f,e,d,c,b,a}, active-low
module product_display #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  result,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_done;

  logic [7:0]  r_last;
  logic [19:0] r_shreg;   // {hundreds, tens, ones, binary}
  logic [2:0]  r_bitcnt;
  logic        r_force;
  logic [11:0] r_bcd;
  logic        r_busy;

  logic [19:0] w_adj;
  logic [19:0] w_shift;

  logic [REFRESH_BITS-1:0] r_cnt;
  logic [1:0]  w_sel;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [3:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;

  assign bcd  = r_bcd;
  assign busy = r_busy;
  assign an   = r_an;
  assign seg  = r_seg;

  // ---------------- conversion FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_force makes the first IDLE cycle after reset convert even when
        // result happens to equal the reset value of r_last.
        if ((result != r_last) || r_force) begin
          w_start     = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_bitcnt == 3'd7) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  always_comb begin
    w_adj = r_shreg;
    for (int i = 0; i < 3; i++) begin
      if (r_shreg[8+4*i +: 4] >= 4'd5) begin
        w_adj[8+4*i +: 4] = r_shreg[8+4*i +: 4] + 4'd3;
      end
    end
    w_shift = w_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_force  <= 1'b1;
      r_busy   <= 1'b0;
      r_bcd    <= 12'd0;
      r_last   <= 8'd0;
      r_shreg  <= 20'd0;
      r_bitcnt <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_last   <= result;
        r_shreg  <= {12'd0, result};
        r_bitcnt <= 3'd0;
        r_force  <= 1'b0;
        r_busy   <= 1'b1;
      end else if (r_state == S_CONV) begin
        r_shreg  <= w_shift;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_done) begin
          r_bcd  <= w_shift[19:8];
          r_busy <= 1'b0;
        end
      end
    end
  end

  // ---------------- display scan ----------------
  function automatic logic [6:0] f_seg7(input logic [3:0] d);
    case (d)
      4'd0:    f_seg7 = 7'b1000000;
      4'd1:    f_seg7 = 7'b1111001;
      4'd2:    f_seg7 = 7'b0100100;
      4'd3:    f_seg7 = 7'b0110000;
      4'd4:    f_seg7 = 7'b0011001;
      4'd5:    f_seg7 = 7'b0010010;
      4'd6:    f_seg7 = 7'b0000010;
      4'd7:    f_seg7 = 7'b1111000;
      4'd8:    f_seg7 = 7'b0000000;
      4'd9:    f_seg7 = 7'b0010000;
      default: f_seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_sel = r_cnt[REFRESH_BITS-1 -: 2];

  // Only the committed bcd register is shown, never the in-flight shreg.
  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (w_sel)
      2'd0: w_digit = r_bcd[3:0];
      2'd1: begin
        w_digit = r_bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        w_digit = r_bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0);
`endif
      end
      default: w_blank = 1'b1;
    endcase
    w_an_nxt  = ~(4'b0001 << w_sel);
    w_seg_nxt = w_blank ? 7'b1111111 : f_seg7(w_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

endmodule
